pll_rst_sequencer: RTL and testbench

//   Reset sequencer placed directly downstream of the Gowin rPLL clock wrapper.

---
 rtl/pll_rst_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_pll_rst_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pll_rst_sequencer.sv
// pll_rst_sequencer
// Reset sequencer running on the PLL output clock. It waits for the PLL lock
// to be stable, holds both resets for a fixed time, releases the peripheral
// reset, then releases the core reset a fixed time later. Lock loss or a
// software reset request in RUN drops both resets again.
module pll_rst_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int RST_HOLD_CYC    = 64,
  parameter int CORE_DELAY_CYC  = 16,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       sw_rst_req,
  output logic       periph_rst_n,
  output logic       core_rst_n,
  output logic       ready,
  output logic [7:0] lock_lost_cnt
);

  // Terminal counts for the three timed phases. Each phase lasts exactly its
  // parameter count, so the exit condition is count-1.
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'(CORE_DELAY_CYC - 1);

  // Three-bit encoding leaves unused codes; they fall into the default branch.
  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    HOLD      = 3'd1,
    PERIPH_UP = 3'd2,
    RUN       = 3'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              periph_reg, periph_next;
  logic              core_reg, core_next;
  logic              ready_reg, ready_next;
  logic [7:0]        lost_reg, lost_next;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   lock_s;

  // First synchronizer stage captures the asynchronous lock input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg[0] <= 1'b0;
    end else begin
      sync_reg[0] <= pll_lock;
    end
  end

  // Remaining synchronizer stages, one flop per stage.
  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      // Shift the lock sample one stage further.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_reg[gi] <= 1'b0;
        end else begin
          sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign lock_s = sync_reg[SYNC_STAGES-1];

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= WAIT_LOCK;
      cnt_reg    <= '0;
      periph_reg <= 1'b0;
      core_reg   <= 1'b0;
      ready_reg  <= 1'b0;
      lost_reg   <= 8'd0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      periph_reg <= periph_next;
      core_reg   <= core_next;
      ready_reg  <= ready_next;
      lost_reg   <= lost_next;
    end
  end

  // Next-state, counter and output decode. Lock loss is checked before the
  // software request so it wins when both occur in the same cycle.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    periph_next = periph_reg;
    core_next   = core_reg;
    ready_next  = ready_reg;
    lost_next   = lost_reg;

    case (state_reg)
      WAIT_LOCK: begin
        periph_next = 1'b0;
        core_next   = 1'b0;
        ready_next  = 1'b0;
        if (lock_s) begin
          if (cnt_reg == LOCK_LAST) begin
            state_next = HOLD;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end else begin
          // A glitch simply restarts qualification; it is not a lock-loss event.
          cnt_next = '0;
        end
      end

      HOLD: begin
        periph_next = 1'b0;
        core_next   = 1'b0;
        ready_next  = 1'b0;
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
          lost_next  = (lost_reg == 8'hFF) ? 8'hFF : lost_reg + 8'd1;
        end else if (cnt_reg == HOLD_LAST) begin
          state_next  = PERIPH_UP;
          cnt_next    = '0;
          periph_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      PERIPH_UP: begin
        periph_next = 1'b1;
        core_next   = 1'b0;
        ready_next  = 1'b0;
        if (!lock_s) begin
          state_next  = WAIT_LOCK;
          cnt_next    = '0;
          periph_next = 1'b0;
          lost_next   = (lost_reg == 8'hFF) ? 8'hFF : lost_reg + 8'd1;
        end else if (cnt_reg == CORE_LAST) begin
          state_next = RUN;
          cnt_next   = '0;
          core_next  = 1'b1;
          ready_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      RUN: begin
        periph_next = 1'b1;
        core_next   = 1'b1;
        ready_next  = 1'b1;
        cnt_next    = '0;
        if (!lock_s) begin
          state_next  = WAIT_LOCK;
          periph_next = 1'b0;
          core_next   = 1'b0;
          ready_next  = 1'b0;
          lost_next   = (lost_reg == 8'hFF) ? 8'hFF : lost_reg + 8'd1;
        end else if (sw_rst_req) begin
          // Software reset skips lock qualification: PLL is known good.
          state_next  = HOLD;
          periph_next = 1'b0;
          core_next   = 1'b0;
          ready_next  = 1'b0;
        end
      end

      default: begin
        state_next  = WAIT_LOCK;
        cnt_next    = '0;
        periph_next = 1'b0;
        core_next   = 1'b0;
        ready_next  = 1'b0;
      end
    endcase
  end

  assign periph_rst_n  = periph_reg;
  assign core_rst_n    = core_reg;
  assign ready         = ready_reg;
  assign lock_lost_cnt = lost_reg;

endmodule

// File: tb/tb_pll_rst_sequencer.sv
// Directed testbench for pll_rst_sequencer with L=8, H=4, D=2, 2 sync stages.
module tb_pll_rst_sequencer;

  logic       clk;
  logic       rst_n;
  logic       pll_lock;
  logic       sw_rst_req;
  logic       periph_rst_n;
  logic       core_rst_n;
  logic       ready;
  logic [7:0] lock_lost_cnt;

  int tests;
  int failed;
  int exp_lost;

  pll_rst_sequencer #(
    .SYNC_STAGES     (2),
    .LOCK_STABLE_CYC (8),
    .RST_HOLD_CYC    (4),
    .CORE_DELAY_CYC  (2),
    .CNT_W           (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_lock      (pll_lock),
    .sw_rst_req    (sw_rst_req),
    .periph_rst_n  (periph_rst_n),
    .core_rst_n    (core_rst_n),
    .ready         (ready),
    .lock_lost_cnt (lock_lost_cnt)
  );

  initial clk = 1'b0;
  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Advance n edges, checking the three reset outputs and the ordering
  // invariant after each edge.
  task automatic run_edges(input string tag, input int n,
                           input logic ep, input logic ec, input logic er);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, "_periph"}, {7'd0, periph_rst_n}, {7'd0, ep});
      chk({tag, "_core"},   {7'd0, core_rst_n},   {7'd0, ec});
      chk({tag, "_ready"},  {7'd0, ready},        {7'd0, er});
      chk({tag, "_order"}, {7'd0, (core_rst_n & ~periph_rst_n)}, 8'd0);
    end
  endtask

  task automatic note_loss();
    exp_lost = (exp_lost == 255) ? 255 : exp_lost + 1;
  endtask

  initial begin
    tests      = 0;
    failed     = 0;
    exp_lost   = 0;
    rst_n      = 1'b0;
    pll_lock   = 1'b0;
    sw_rst_req = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_periph", {7'd0, periph_rst_n}, 8'd0);
    chk("rst_core",   {7'd0, core_rst_n},   8'd0);
    chk("rst_ready",  {7'd0, ready},        8'd0);
    chk("rst_lost",   lock_lost_cnt,        8'd0);
    rst_n = 1'b1;
    tick();
    $display("[TB] reset state checked");

    // 1: power-up; periph at edge 14, core/ready at edge 16
    pll_lock = 1'b1;
    run_edges("pwr_low", 13, 1'b0, 1'b0, 1'b0);
    run_edges("pwr_periph", 2, 1'b1, 1'b0, 1'b0);
    run_edges("pwr_run", 1, 1'b1, 1'b1, 1'b1);
    chk("pwr_lost", lock_lost_cnt, 8'(exp_lost));
    $display("[TB] power-up sequence checked");

    // 3: lock loss in RUN, then full re-qualification
    pll_lock = 1'b0;
    run_edges("loss_still_run", 2, 1'b1, 1'b1, 1'b1);
    run_edges("loss_drop", 1, 1'b0, 1'b0, 1'b0);
    note_loss();
    chk("loss_lost", lock_lost_cnt, 8'(exp_lost));
    pll_lock = 1'b1;
    run_edges("reacq_low", 13, 1'b0, 1'b0, 1'b0);
    run_edges("reacq_periph", 2, 1'b1, 1'b0, 1'b0);
    run_edges("reacq_run", 1, 1'b1, 1'b1, 1'b1);
    $display("[TB] lock loss in RUN checked");

    // 4: software reset in RUN -> HOLD, no lock wait
    sw_rst_req = 1'b1;
    run_edges("sw_drop", 1, 1'b0, 1'b0, 1'b0);
    sw_rst_req = 1'b0;
    run_edges("sw_hold", 3, 1'b0, 1'b0, 1'b0);
    run_edges("sw_periph", 2, 1'b1, 1'b0, 1'b0);
    run_edges("sw_run", 1, 1'b1, 1'b1, 1'b1);
    chk("sw_lost", lock_lost_cnt, 8'(exp_lost));
    $display("[TB] software reset checked");

    // 5a: sw_rst_req held through WAIT_LOCK, HOLD and PERIPH_UP is ignored
    pll_lock = 1'b0;
    run_edges("ign_pre", 2, 1'b1, 1'b1, 1'b1);
    run_edges("ign_drop", 1, 1'b0, 1'b0, 1'b0);
    note_loss();
    pll_lock   = 1'b1;
    sw_rst_req = 1'b1;
    run_edges("ign_low", 13, 1'b0, 1'b0, 1'b0);
    run_edges("ign_periph", 2, 1'b1, 1'b0, 1'b0);
    run_edges("ign_run", 1, 1'b1, 1'b1, 1'b1);
    sw_rst_req = 1'b0;
    chk("ign_lost", lock_lost_cnt, 8'(exp_lost));
    $display("[TB] sw_rst_req outside RUN checked");

    // 5b: lock loss and sw_rst_req together -> WAIT_LOCK, count once
    pll_lock = 1'b0;
    run_edges("both_pre", 2, 1'b1, 1'b1, 1'b1);
    sw_rst_req = 1'b1;
    run_edges("both_drop", 1, 1'b0, 1'b0, 1'b0);
    note_loss();
    sw_rst_req = 1'b0;
    chk("both_lost", lock_lost_cnt, 8'(exp_lost));
    pll_lock = 1'b1;
    run_edges("both_low", 13, 1'b0, 1'b0, 1'b0);
    chk("both_lost_after", lock_lost_cnt, 8'(exp_lost));
    run_edges("both_periph", 2, 1'b1, 1'b0, 1'b0);
    run_edges("both_run", 1, 1'b1, 1'b1, 1'b1);
    $display("[TB] simultaneous loss and sw_rst_req checked");

    // 2: one-cycle lock glitch during WAIT_LOCK restarts qualification
    pll_lock = 1'b0;
    run_edges("gl_pre", 2, 1'b1, 1'b1, 1'b1);
    run_edges("gl_drop", 1, 1'b0, 1'b0, 1'b0);
    note_loss();
    pll_lock = 1'b1;
    run_edges("gl_a", 6, 1'b0, 1'b0, 1'b0);
    pll_lock = 1'b0;
    run_edges("gl_b", 1, 1'b0, 1'b0, 1'b0);
    pll_lock = 1'b1;
    run_edges("gl_c", 13, 1'b0, 1'b0, 1'b0);
    run_edges("gl_periph", 2, 1'b1, 1'b0, 1'b0);
    run_edges("gl_run", 1, 1'b1, 1'b1, 1'b1);
    chk("gl_lost", lock_lost_cnt, 8'(exp_lost));
    $display("[TB] lock glitch checked");

    // 6: saturation of the lock-loss counter
    pll_lock = 1'b0;
    tick(); tick(); tick();
    note_loss();
    for (int k = 0; k < 300; k++) begin
      pll_lock = 1'b1;
      for (int j = 0; j < 11; j++) tick();
      pll_lock = 1'b0;
      tick(); tick(); tick();
      note_loss();
      chk("sat_step", lock_lost_cnt, 8'(exp_lost));
    end
    chk("sat_final", lock_lost_cnt, 8'd255);
    $display("[TB] saturation checked, lock_lost_cnt=%0d", lock_lost_cnt);

    // 6: async reset mid-PERIPH_UP clears everything without a clock edge
    pll_lock = 1'b1;
    run_edges("ar_low", 13, 1'b0, 1'b0, 1'b0);
    run_edges("ar_periph", 1, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_periph0", {7'd0, periph_rst_n}, 8'd0);
    chk("ar_core0",   {7'd0, core_rst_n},   8'd0);
    chk("ar_ready0",  {7'd0, ready},        8'd0);
    chk("ar_lost0",   lock_lost_cnt,        8'd0);
    $display("[TB] async reset checked");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
